// File: rtl/grad_mag_sq_pipeline_pkg.sv
// Shared types for the gradient-magnitude radicand stage: pixel sideband
// bundle and the downstream square-root latency helper.
package grad_pkg;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
    logic eof;
  } sideband_t;

  localparam int SB_W = $bits(sideband_t);

  function automatic int sqrt_lat(input int rad_w);
    return rad_w / 2;
  endfunction

endpackage

// File: rtl/grad_mag_sq_pipeline_sideband_delay.sv
// Fixed-depth shift register for the pixel sideband; clears on async reset.
// DEPTH=0 degenerates to a wire.
module sideband_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q_o = d_i;
    end else begin : g_shift
      logic [DEPTH*W-1:0] shift_q;

      // Oldest entry sits in the top W bits; the cast drops it as d_i enters.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          shift_q <= '0;
        end else begin
          shift_q <= (DEPTH*W)'({shift_q, d_i});
        end
      end

      assign q_o = shift_q[DEPTH*W-1 -: W];
    end
  endgenerate

endmodule

// File: rtl/grad_mag_sq_pipeline.sv
// Gx^2+Gy^2 radicand pipeline (3 clocks) feeding the sqrt, with sideband
// delayed to match the root, and per-frame maximum radicand tracking.
module grad_mag_sq_pipeline
  import grad_pkg::*;
#(
  parameter int GW       = 16,
  parameter int RAD_W    = 32,
  parameter int SQRT_LAT = sqrt_lat(RAD_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic                 in_eol,
  input  logic                 in_eof,
  input  logic signed [GW-1:0] in_gx,
  input  logic signed [GW-1:0] in_gy,
  output logic [RAD_W-1:0]     rad,
  output logic                 rad_valid,
  output logic                 rad_sof,
  output logic                 rad_eol,
  output logic                 rad_eof,
  output logic                 mag_valid,
  output logic                 mag_sof,
  output logic                 mag_eol,
  output logic                 mag_eof,
  output logic [RAD_W-1:0]     frame_max,
  output logic                 frame_max_valid
);

  localparam int PW = 2 * GW;

  sideband_t sb_in, sb1_q, sb2_q, sb3_q, mag_sb;

  logic signed [GW-1:0] gx_q, gy_q;
  logic signed [PW-1:0] sqx_s, sqy_s;
  logic [PW-1:0]        sqx_q, sqy_q, sum;
  logic [RAD_W-1:0]     rad_q, cand;
  logic [RAD_W-1:0]     run_max_q, run_max_d;
  logic [RAD_W-1:0]     frame_max_q, frame_max_d;
  logic                 fmv_q, fmv_d;

  always_comb begin
    sb_in       = '0;
    sb_in.valid = in_valid;
    sb_in.sof   = in_sof & in_valid;
    sb_in.eol   = in_eol & in_valid;
    sb_in.eof   = in_eof & in_valid;
  end

  // Widen before multiplying so (-2^(GW-1))^2 is representable.
  assign sqx_s = PW'(gx_q) * PW'(gx_q);
  assign sqy_s = PW'(gy_q) * PW'(gy_q);
  // Max sum is 2^(PW-1), so PW bits cannot overflow.
  assign sum   = sqx_q + sqy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb1_q       <= '0;
      sb2_q       <= '0;
      sb3_q       <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
      sqx_q       <= '0;
      sqy_q       <= '0;
      rad_q       <= '0;
      run_max_q   <= '0;
      frame_max_q <= '0;
      fmv_q       <= 1'b0;
    end else begin
      sb1_q <= sb_in;
      sb2_q <= sb1_q;
      sb3_q <= sb2_q;
      if (in_valid) begin
        gx_q <= in_gx;
        gy_q <= in_gy;
      end
      if (sb1_q.valid) begin
        sqx_q <= $unsigned(sqx_s);
        sqy_q <= $unsigned(sqy_s);
      end
      if (sb2_q.valid) begin
        rad_q <= RAD_W'(sum);
      end
      run_max_q   <= run_max_d;
      frame_max_q <= frame_max_d;
      fmv_q       <= fmv_d;
    end
  end

  always_comb begin
    cand        = sb3_q.sof ? rad_q : ((rad_q > run_max_q) ? rad_q : run_max_q);
    run_max_d   = run_max_q;
    frame_max_d = frame_max_q;
    fmv_d       = 1'b0;
    if (sb3_q.valid) begin
      run_max_d = cand;
      if (sb3_q.eof) begin
        frame_max_d = cand;
        fmv_d       = 1'b1;
      end
    end
  end

  sideband_delay #(
    .DEPTH (SQRT_LAT),
    .W     (SB_W)
  ) u_mag_delay (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (sb3_q),
    .q_o   (mag_sb)
  );

  assign rad             = rad_q;
  assign rad_valid       = sb3_q.valid;
  assign rad_sof         = sb3_q.sof;
  assign rad_eol         = sb3_q.eol;
  assign rad_eof         = sb3_q.eof;
  assign mag_valid       = mag_sb.valid;
  assign mag_sof         = mag_sb.sof;
  assign mag_eol         = mag_sb.eol;
  assign mag_eof         = mag_sb.eof;
  assign frame_max       = frame_max_q;
  assign frame_max_valid = fmv_q;

endmodule

// File: doc/grad_mag_sq_pipeline.md
Name: grad_mag_sq_pipeline

Overview:
Pipelined stage directly upstream of the square-root pipeline in the edge-magnitude path. It takes signed horizontal and vertical gradients (Gx, Gy) from the kernel filter and computes Gx²+Gy² as the radicand. It also carries the pixel sideband (valid/sof/eol/eof) through a delay line matched to the square-root latency, so downstream logic can tag each root. It tracks the per-frame maximum radicand for auto-scaling.

Parameters:
GW, 16, width of signed Gx/Gy inputs
RAD_W, 32, radicand width; must be even and >= 2*GW; equals the downstream sqrt WIDTH
SQRT_LAT, RAD_W/2, downstream sqrt latency in clocks (rad in -> root out)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  pixel qualifier
in_sof  in  1  first pixel of frame (qualified by in_valid)
in_eol  in  1  last pixel of line
in_eof  in  1  last pixel of frame
in_gx  in  GW  signed horizontal gradient
in_gy  in  GW  signed vertical gradient
rad  out  RAD_W  Gx²+Gy², zero-extended; drives sqrt rad
rad_valid  out  1  rad qualifier
rad_sof / rad_eol / rad_eof  out  1 each  sideband aligned with rad
mag_valid  out  1  valid aligned with sqrt root output
mag_sof / mag_eol / mag_eof  out  1 each  sideband aligned with sqrt root
frame_max  out  RAD_W  max rad over last completed frame
frame_max_valid  out  1  one-cycle pulse when frame_max updates

Behaviour:
- Reset (async, rst=1): all valid/sideband flops, rad, frame_max, running max, frame_max_valid = 0. Release is synchronous to clk.
- No backpressure. Pipeline is free-running and advances every clock.
- S1: register in_gx, in_gy, and sideband. Data flops are enabled by in_valid. Sideband flops always load, and sof/eol/eof are ANDed with in_valid.
- S2: register signed squares (2*GW bits each, unsigned result). Data is enabled by the S1 valid.
- S3: register the sum into rad. The sum is 2*GW bits, which is sufficient: max is 2*(2^(GW-1))² = 2^(2GW-1). Zero-extend to RAD_W.
- Latency: in_* to rad/rad_valid = 3 clocks. rad holds its last value while rad_valid=0.
- Gx = Gy = -2^(GW-1) is legal and must give 2^(2GW-1) with no overflow.
- Sideband delay: {rad_valid, rad_sof, rad_eol, rad_eof} passes through a SQRT_LAT-deep shift register to mag_*.
  - mag_* asserts exactly SQRT_LAT clocks after the matching rad_*, i.e. in the cycle the sqrt root for that rad is presented.
  - Total in_valid to mag_valid = 3 + SQRT_LAT.
- Frame max (evaluated on rad_valid only):
  - rad_sof: run_max <= rad.
  - Otherwise: run_max <= max(run_max, rad).
  - rad_eof: frame_max <= max of run_max and rad (or rad alone if rad_sof is also set); frame_max_valid=1 for exactly one clock.
  - sof and eof in the same pixel (single-pixel frame): frame_max = that rad.
  - eof with no prior sof since reset: frame_max = max(0-initialised run_max, rad).
  - Bubbles (rad_valid=0) never affect run_max.
- Reset mid-frame: in-flight pixels are discarded, and no mag_valid or frame_max_valid is produced for them. The first frame after reset starts at the next in_sof.
- Back-to-back frames: eof followed by sof on the next valid pixel are handled with no gap cycles required.

Decomposition:
- Package grad_pkg:
  - typedef struct packed sideband_t {valid, sof, eol, eof}
  - function sqrt_lat(rad_w) returning rad_w/2
  - localparam SB_W = $bits(sideband_t)
- Sub-module sideband_delay (params DEPTH, W): async-reset shift register for sideband_t, reset to 0; DEPTH=0 is a pass-through. It is instantiated for the SQRT_LAT alignment.
- Squaring, summing and frame-max stay in the top module.

Test Plan:
- Defaults (GW=16, RAD_W=32). Single pixel gx=3, gy=4, sof=eof=1 at cycle 0 -> expected response:
  - rad=25, rad_valid=1 at cycle 3
  - frame_max=25 and frame_max_valid pulse at cycle 4
  - mag_valid/mag_sof/mag_eof=1 at cycle 19; chained sqrt root=5
- Extremes: gx=gy=-32768 -> rad=0x8000_0000. Then gx=32767, gy=0 -> rad=0x3FFF_0001. Then gx=gy=0 -> rad=0.
- Frame of 4 pixels, rads 9, 100, 4, 49, with bubbles inserted between pixels -> frame_max=100 after eof; rad is held during bubbles; mag_valid has exactly 4 pulses, matching the spacing of in_valid.
- Two back-to-back frames, max 100 then max 16 (second frame sof on the pixel after eof) -> frame_max=100 then 16, one pulse each, with no carry-over between frames.
- rst asserted mid-frame with 3 pixels in S1-S3 and more in the delay line -> all outputs 0 immediately (asynchronously); no mag_valid or frame_max_valid until the next in_sof frame.
- Random gx/gy stream of 10k pixels through a scoreboard model plus the chained sqrt -> rad = gx²+gy² exactly, mag_* aligned to each root, root = floor(sqrt(rad)).
